// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and occupancy helper for the skid pipeline stage
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} pipe_state_t;
  localparam int OCC_W = 2;
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    return (s == ST_FULL) ? 2'd2 : (s == ST_ONE) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: event counter that sticks at all-ones instead of wrapping
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // count up on inc, hold once saturated
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_skid_stage_reg.sv
// pipe_skid_stage_reg: valid/ready pipeline register with 2-entry skid buffer; PIPE_STAGE_STATS_EN enables stall/flush counters
module pipe_skid_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  pipe_state_t       state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q, main_d, skid_d;
  logic              main_en, skid_en, in_beat;
  assign in_beat   = in_valid & in_ready;
  assign out_valid = state != ST_EMPTY;
  assign out_data  = main_q;
  assign occupancy = occ_of(state);
  // next state and payload-register loads; flush overrides everything, and in FULL no in beat can occur
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = in_data;
    skid_d    = in_data;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_en   = CLEAR_ON_FLUSH != 0;
      skid_en   = CLEAR_ON_FLUSH != 0;
      main_d    = '0;
      skid_d    = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          state_nxt = in_beat ? ST_ONE : ST_EMPTY;
          main_en   = in_beat;
        end
        ST_ONE: begin
          state_nxt = (in_beat && !out_ready) ? ST_FULL : (!in_beat && out_ready) ? ST_EMPTY : ST_ONE;
          main_en   = in_beat & out_ready;
          skid_en   = in_beat & ~out_ready;
        end
        ST_FULL: begin
          state_nxt = out_ready ? ST_ONE : ST_FULL;
          main_en   = out_ready;
          main_d    = skid_q;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end
  // state, registered in_ready and payload registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= state_nxt != ST_FULL;
      if (main_en) main_q <= main_d;
      if (skid_en) skid_q <= skid_d;
    end
`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(out_valid & ~out_ready), .cnt(stall_cnt)
  );
  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush & (state != ST_EMPTY)), .cnt(flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// tb_pipe_skid_stage_reg: vector table plus scoreboard check of the skid pipeline stage
module tb_pipe_skid_stage_reg;
  localparam int DW = 64;
  localparam int CW = 4;
`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic [DW-1:0] od;
    logic [1:0]    occ;
    logic          ir;
  } vec_t;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic in_ready, out_valid, in_ready0, out_valid0;
  logic [DW-1:0] out_data, out_data0;
  logic [1:0] occupancy, occupancy0;
  logic [CW-1:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] sb[$];
  vec_t vt[$];
  always #5 clk = ~clk;
  pipe_skid_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_skid_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .occupancy(occupancy0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                              input logic ov, input logic [DW-1:0] od, input logic [1:0] occ, input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction
  // scoreboard: expected beats queued on accepted input, compared when the stage emits them
  always @(negedge clk) begin
    if (!rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got %0h want none", out_data);
        end else chk("sb_data", out_data, sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_data);
    end
  end
  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_occ", {62'd0, occupancy}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", {63'd0, in_ready}, 1);
    chk("rst_stall", {60'd0, stall_cnt}, 0);
    chk("rst_flush", {60'd0, flush_cnt}, 0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) vt.push_back(mk(1, DW'(k), 1, 0, 1, DW'(k), 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 0, 8, 0, 1));
    vt.push_back(mk(1, 'hA, 0, 0, 1, 'hA, 1, 1));
    vt.push_back(mk(1, 'hB, 0, 0, 1, 'hA, 2, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 'hA, 2, 0));
    vt.push_back(mk(0, 0, 1, 0, 1, 'hB, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 0, 'hB, 0, 1));
    vt.push_back(mk(1, 'hA, 0, 0, 1, 'hA, 1, 1));
    vt.push_back(mk(1, 'hB, 0, 0, 1, 'hA, 2, 0));
    vt.push_back(mk(1, 'hC, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    foreach (vt[i]) begin
      step(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl);
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].ov});
      chk($sformatf("v%0d_out_data", i), out_data, vt[i].od);
      chk($sformatf("v%0d_occ", i), {62'd0, occupancy}, {62'd0, vt[i].occ});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].ir});
    end
    step(1, 'h5, 0, 0);
    chk("f1_out_data", out_data, 'h5);
    step(0, 0, 1, 1);
    chk("f1_occ", {62'd0, occupancy}, 0);
    chk("f1_out_valid", {63'd0, out_valid}, 0);
    chk("f1_clear_data", out_data, 0);
    chk("f1_hold_data", out_data0, 'h5);
    chk("f1_hold_valid", {63'd0, out_valid0}, 0);
    step(1, 'h1, 0, 0);
    step(1, 'h2, 0, 0);
    chk("r_full_occ", {62'd0, occupancy}, 2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("r_out_valid", {63'd0, out_valid}, 0);
    chk("r_occ", {62'd0, occupancy}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("r_in_ready", {63'd0, in_ready}, 1);
    step(1, 'h7, 1, 0);
    chk("r_out_valid7", {63'd0, out_valid}, 1);
    chk("r_out_data7", out_data, 'h7);
    step(0, 0, 1, 0);
    chk("r_drained", {63'd0, out_valid}, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    rst = 1'b1;
    chk("s_stall0", {60'd0, stall_cnt}, 0);
    step(1, 'h9, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    chk("s_stall5", {60'd0, stall_cnt}, STATS ? 5 : 0);
    repeat (20) step(0, 0, 0, 0);
    chk("s_stall_sat", {60'd0, stall_cnt}, STATS ? 15 : 0);
    step(0, 0, 0, 1);
    chk("s_flush1", {60'd0, flush_cnt}, STATS ? 1 : 0);
    repeat (3) step(0, 0, 0, 1);
    chk("s_flush_empty", {60'd0, flush_cnt}, STATS ? 1 : 0);
    chk("s_stall_hold", {60'd0, stall_cnt}, STATS ? 15 : 0);
    step(0, 0, 1, 0);
    chk("sb_empty", DW'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
